// File: rtl/misc_op_sequencer_if.sv
// Port bundle for misc_op_sequencer: decoder op port, direct A/F load port, misc ALU link, status.
// With MISC_SEQ_OPCOUNT_EN defined the bundle also carries the 16-bit legal-op counter.
interface misc_op_sequencer_if;
  logic       i_Op_Valid;
  logic [7:0] i_Opcode;
  logic       o_Op_Ready;
  logic       i_Ld_Valid;
  logic [1:0] i_Ld_Sel;
  logic [7:0] i_Ld_A;
  logic [3:0] i_Ld_F;
  logic       o_Ld_Ready;
  logic [7:0] o_Alu_A;
  logic [3:0] o_Alu_F;
  logic [1:0] o_Alu_Op;
  logic [7:0] i_Alu_A;
  logic [3:0] i_Alu_F;
  logic [7:0] o_A;
  logic [3:0] o_F;
  logic       o_Done;
  logic       o_Op_Error;
`ifdef MISC_SEQ_OPCOUNT_EN
  logic [15:0] o_Op_Count;
`endif

  modport slave (
`ifdef MISC_SEQ_OPCOUNT_EN
    output o_Op_Count,
`endif
    input  i_Op_Valid, i_Opcode, i_Ld_Valid, i_Ld_Sel, i_Ld_A, i_Ld_F, i_Alu_A, i_Alu_F,
    output o_Op_Ready, o_Ld_Ready, o_Alu_A, o_Alu_F, o_Alu_Op, o_A, o_F, o_Done, o_Op_Error
  );

  modport master (
`ifdef MISC_SEQ_OPCOUNT_EN
    input  o_Op_Count,
`endif
    output i_Op_Valid, i_Opcode, i_Ld_Valid, i_Ld_Sel, i_Ld_A, i_Ld_F, i_Alu_A, i_Alu_F,
    input  o_Op_Ready, o_Ld_Ready, o_Alu_A, o_Alu_F, o_Alu_Op, o_A, o_F, o_Done, o_Op_Error
  );
endinterface

// File: rtl/misc_op_sequencer.sv
// Owns A/F and sequences DAA/CPL/SCF/CCF through the external misc ALU, arbitrating op vs load port.
// Optional MISC_SEQ_OPCOUNT_EN adds a wrapping 16-bit count of legal-op writebacks.
module misc_op_sequencer #(
  parameter int         T_CYCLES = 4,
  parameter logic [7:0] A_RESET  = 8'h01,
  parameter logic [3:0] F_RESET  = 4'hB
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  misc_op_sequencer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(T_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d;
  logic [3:0] f_q, f_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [3:0] alu_f_q, alu_f_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       prio_ld_q, prio_ld_d;

  logic idle;
  logic op_fire;
  logic ld_fire;
  logic op_legal;
  logic wb;

  // Arbitration: prio_ld_q set means the load port wins the next tie.
  always_comb begin
    idle     = (state_q == IDLE);
    op_legal = (bus.i_Opcode[7:5] == 3'b001) && (bus.i_Opcode[2:0] == 3'b111);
    op_fire  = idle && bus.i_Op_Valid && (!bus.i_Ld_Valid || !prio_ld_q);
    ld_fire  = idle && bus.i_Ld_Valid && (!bus.i_Op_Valid || prio_ld_q);
    wb       = (state_q == EXEC) && (cnt_q == 4'd0);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_fire && op_legal) state_d = EXEC;
      EXEC:    if (wb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_Op_Ready = idle;
    bus.o_Ld_Ready = idle;

    cnt_d     = cnt_q;
    a_d       = a_q;
    f_d       = f_q;
    alu_a_d   = alu_a_q;
    alu_f_d   = alu_f_q;
    alu_op_d  = alu_op_q;
    prio_ld_d = prio_ld_q;
    done_d    = wb;
    err_d     = op_fire && !op_legal;

    // The flag passes to the loser only when both ports were asking.
    if (op_fire && bus.i_Ld_Valid) prio_ld_d = 1'b1;
    if (ld_fire && bus.i_Op_Valid) prio_ld_d = 1'b0;

    if (op_fire && op_legal) begin
      alu_a_d  = a_q;
      alu_f_d  = f_q;
      alu_op_d = bus.i_Opcode[4:3];
      cnt_d    = CNT_LOAD;
    end else if (state_q == EXEC && !wb) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (wb) begin
      a_d = bus.i_Alu_A;
      f_d = bus.i_Alu_F;
    end

    if (ld_fire) begin
      if (bus.i_Ld_Sel[1]) a_d = bus.i_Ld_A;
      if (bus.i_Ld_Sel[0]) f_d = bus.i_Ld_F;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q     <= 4'd0;
      a_q       <= A_RESET;
      f_q       <= F_RESET;
      alu_a_q   <= 8'h00;
      alu_f_q   <= 4'h0;
      alu_op_q  <= 2'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      prio_ld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      f_q       <= f_d;
      alu_a_q   <= alu_a_d;
      alu_f_q   <= alu_f_d;
      alu_op_q  <= alu_op_d;
      done_q    <= done_d;
      err_q     <= err_d;
      prio_ld_q <= prio_ld_d;
    end
  end

  assign bus.o_Alu_A    = alu_a_q;
  assign bus.o_Alu_F    = alu_f_q;
  assign bus.o_Alu_Op   = alu_op_q;
  assign bus.o_A        = a_q;
  assign bus.o_F        = f_q;
  assign bus.o_Done     = done_q;
  assign bus.o_Op_Error = err_q;

`ifdef MISC_SEQ_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (wb) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) op_count_q <= 16'd0;
    else         op_count_q <= op_count_d;
  end

  assign bus.o_Op_Count = op_count_q;
`endif

endmodule
